// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C memory-window target.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } i2c_tgt_state_t;

  localparam logic I2C_RW_READ = 1'b1;
  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DATA_W      = 8;
  // Holds 0..8 so the read path can tell "8th bit sent" apart from "bit 0".
  localparam int unsigned BIT_CNT_W   = 4;

endpackage

// File: rtl/i2c_target_mem_if.sv
// Synchronous byte port between the I2C target and its backing memory.
interface i2c_target_mem_if
  import i2c_pkg::*;
#(
  parameter int unsigned AW = 8
) ();

  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_re,
    output mem_rdata
  );

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizes raw SCL/SDA and produces registered edge and START/STOP pulses.
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sr;
  logic [SYNC_STAGES-1:0] sda_sr;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_c;
  logic                   sda_c;

  assign scl_c = scl_sr[SYNC_STAGES-1];
  assign sda_c = sda_sr[SYNC_STAGES-1];

  // Sync chains reset to the idle-high bus level so reset creates no false START/STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sr    <= '1;
      sda_sr    <= '1;
      scl_d     <= 1'b1;
      sda_d     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_s     <= 1'b1;
    end else begin
      scl_sr    <= {scl_sr[SYNC_STAGES-2:0], scl_i};
      sda_sr    <= {sda_sr[SYNC_STAGES-2:0], sda_i};
      scl_d     <= scl_c;
      sda_d     <= sda_c;
      scl_rise  <= scl_c & ~scl_d;
      scl_fall  <= ~scl_c & scl_d;
      start_det <= scl_c & scl_d & sda_d & ~sda_c;
      stop_det  <= scl_c & scl_d & ~sda_d & sda_c;
      sda_s     <= sda_c;
    end
  end

endmodule

// File: rtl/i2c_target_mem.sv
// I2C target exposing an EEPROM-style byte-addressed window over a memory port.
module i2c_target_mem
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned AW       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scl_i,
  input  logic                sda_i,
  output logic                sda_oe,
  output logic                busy,
  i2c_target_mem_if.master    mem
);

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_s;

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_tgt_state_t        state_q, state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]     shreg_q, shreg_d;
  logic [DATA_W-1:0]     tx_q, tx_d;
  logic [AW-1:0]         ptr_q, ptr_d;
  logic [AW-1:0]         mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_re_q, mem_re_d;
  logic                  rd_pend_q;
  logic                  rd_ack_q, rd_ack_d;
  logic                  rw_q, rw_d;
  logic                  sda_oe_d;
  logic                  busy_d;
  logic [DATA_W-1:0]     rx_byte_c;
  logic                  last_bit_c;

  assign rx_byte_c  = {shreg_q[DATA_W-2:0], sda_s};
  assign last_bit_c = (bit_cnt_q == BIT_CNT_W'(7));

  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_re    = mem_re_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      tx_q        <= '0;
      ptr_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_ack_q    <= 1'b0;
      rw_q        <= 1'b0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      rd_pend_q   <= mem_re_q;
      rd_ack_q    <= rd_ack_d;
      rw_q        <= rw_d;
      sda_oe      <= sda_oe_d;
      busy        <= busy_d;
    end
  end

  // Next-state and bus behaviour; START/STOP override any bit processing.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    tx_d        = rd_pend_q ? mem.mem_rdata : tx_q;
    ptr_d       = ptr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    rd_ack_d    = rd_ack_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe;
    busy_d      = busy;

    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      rd_ack_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      rd_ack_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shreg_d   = rx_byte_c;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (last_bit_c) begin
              bit_cnt_d = '0;
              if (rx_byte_c[7:1] == DEV_ADDR) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = rx_byte_c[0];
                if (rx_byte_c[0] == I2C_RW_READ) begin
                  mem_re_d   = 1'b1;
                  mem_addr_d = ptr_q;
                end
              end else begin
                state_d = WAIT_STOP;
              end
            end
          end
        end

        // First fall drives the ACK, second fall ends it.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_d = 1'b1;
            end else if (rw_q == I2C_RW_READ) begin
              sda_oe_d  = ~tx_q[DATA_W-1];
              tx_d      = {tx_q[DATA_W-2:0], 1'b0};
              bit_cnt_d = '0;
              state_d   = RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = PTR;
            end
          end
        end

        PTR: begin
          if (scl_rise) begin
            shreg_d   = rx_byte_c;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (last_bit_c) begin
              bit_cnt_d = '0;
              ptr_d     = AW'(rx_byte_c);
              state_d   = PTR_ACK;
            end
          end
        end

        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WDATA;
            end
          end
        end

        WDATA: begin
          if (scl_rise) begin
            shreg_d   = rx_byte_c;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (last_bit_c) begin
              bit_cnt_d   = '0;
              mem_we_d    = 1'b1;
              mem_addr_d  = ptr_q;
              mem_wdata_d = rx_byte_c;
              ptr_d       = ptr_q + AW'(1);
              state_d     = WDATA_ACK;
            end
          end
        end

        // bit_cnt counts rises; the fall after the 8th rise hands SDA back.
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end else if (scl_fall) begin
            if (bit_cnt_q == BIT_CNT_W'(8)) begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + AW'(1);
              rd_ack_d = 1'b0;
              state_d  = RDATA_ACK;
            end else begin
              sda_oe_d = ~tx_q[DATA_W-1];
              tx_d     = {tx_q[DATA_W-2:0], 1'b0};
            end
          end
        end

        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              rd_ack_d   = 1'b1;
              mem_re_d   = 1'b1;
              mem_addr_d = ptr_q;
            end else begin
              state_d = WAIT_STOP;
            end
          end else if (scl_fall && rd_ack_q) begin
            sda_oe_d  = ~tx_q[DATA_W-1];
            tx_d      = {tx_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = '0;
            rd_ack_d  = 1'b0;
            state_d   = RDATA;
          end
        end

        IDLE, WAIT_STOP: begin
        end

        default: state_d = IDLE;
      endcase
    end
  end

endmodule
